// File: rtl/alu_muldiv_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_pkg                                                          |
// | Brief   : Shared op encodings, FSM state codes and width default for the   |
// |           RV32M multiply/divide unit.                                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int c_xlen = 32;

  typedef logic [2:0] md_op_t;

  // funct3 encodings of the M extension
  localparam md_op_t MD_MUL    = 3'd0;
  localparam md_op_t MD_MULH   = 3'd1;
  localparam md_op_t MD_MULHSU = 3'd2;
  localparam md_op_t MD_MULHU  = 3'd3;
  localparam md_op_t MD_DIV    = 3'd4;
  localparam md_op_t MD_DIVU   = 3'd5;
  localparam md_op_t MD_REM    = 3'd6;
  localparam md_op_t MD_REMU   = 3'd7;

  // FSM state codes
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_mul   = 3'd1;
  localparam logic [2:0] c_st_div   = 3'd2;
  localparam logic [2:0] c_st_fixup = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  // rs1 is treated as signed for these ops
  function automatic logic op_signed_a(input md_op_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_signed_b(input md_op_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_muldiv_seq_if                                                |
// | Brief   : Request/result bundle between the issue stage and the mul/div    |
// |           unit.                                                            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, valid, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, valid, result
  );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq_sign_fix.sv
// +----------------------------------------------------------------------------+
// | Module  : muldiv_sign_fix                                                  |
// | Brief   : Applies operand signs to the unsigned magnitude result of the    |
// |           iterative datapath and selects the architectural result word.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module muldiv_sign_fix
  import alu_pkg::*;
#(
  parameter int XLEN = c_xlen
) (
  input  logic [2:0]        i_op,
  input  logic [2*XLEN-1:0] i_acc,     // product, or {remainder, quotient}
  input  logic              i_sign_a,
  input  logic              i_sign_b,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  assign w_prod = (i_sign_a ^ i_sign_b) ? -i_acc : i_acc;
  assign w_quot = (i_sign_a ^ i_sign_b) ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
  // Remainder takes the sign of the dividend only
  assign w_rem  = i_sign_a ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

  // Pick the word the op architecturally returns
  always_comb begin
    o_result = w_rem;
    case (i_op)
      MD_MUL:                        o_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               o_result = w_quot;
      default:                       o_result = w_rem;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_muldiv_seq                                                   |
// | Brief   : Multi-cycle RV32M multiply/divide unit, radix-2 (1 bit/cycle).   |
// |           Unsigned magnitudes iterate in MUL/DIV, signs are applied in     |
// |           FIXUP, result is presented for one cycle in DONE.                |
// |           Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply at      |
// |           accept; divides stay iterative.                                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = c_xlen
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_muldiv_seq_if.slave md
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2:0]        r_state;
  logic [2:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [2*XLEN-1:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_dvs;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_result;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic              w_last;
  logic [XLEN-1:0]   w_fix_res;

  // Operand signs and magnitudes formed from the request as presented
  assign w_sa    = op_signed_a(md.op) & md.a[XLEN-1];
  assign w_sb    = op_signed_b(md.op) & md.b[XLEN-1];
  assign w_mag_a = w_sa ? -md.a : md.a;
  assign w_mag_b = w_sb ? -md.b : md.b;

  // Divide corner cases that complete without iterating
  assign w_b_zero  = (md.b == '0);
  assign w_ovf     = ((md.op == MD_DIV) || (md.op == MD_REM)) &&
                     (md.a == {1'b1, {(XLEN-1){1'b0}}}) && (&md.b);
  assign w_special = md.op[2] && (w_b_zero || w_ovf);
  // op[1] distinguishes REM* from DIV*
  assign w_special_res = w_b_zero ? (md.op[1] ? md.a : '1)
                                  : (md.op[1] ? '0   : md.a);

  // Shift-add step: add multiplicand into the high half when multiplier LSB is set
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  assign w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = w_div_sh - {1'b0, r_dvs};
  assign w_div_next = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_last = (r_cnt == CW'(XLEN - 1));

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_op     (r_op),
    .i_acc    (r_acc),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .o_result (w_fix_res)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fast_res;
  logic                     w_unused_fprod;

  // Sign-extend by one bit so a single signed multiply covers all MUL variants
  assign w_fa           = {w_sa, md.a};
  assign w_fb           = {w_sb, md.b};
  assign w_fprod        = w_fa * w_fb;
  assign w_fast_res     = (md.op == MD_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
  assign w_unused_fprod = ^w_fprod[2*XLEN+1:2*XLEN];
`endif

  // Control FSM and iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_op     <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
    end else if (md.flush) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (md.start) begin
            r_op     <= md.op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_cnt    <= '0;
            r_acc    <= {{XLEN{1'b0}}, w_mag_a};
            r_dvs    <= w_mag_b;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= c_st_done;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!md.op[2]) begin
              r_result <= w_fast_res;
              r_state  <= c_st_done;
            end
`endif
            else begin
              r_state <= md.op[2] ? c_st_div : c_st_mul;
            end
          end else begin
            r_state <= c_st_idle;
          end
        end
        c_st_mul: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= c_st_fixup;
        end
        c_st_div: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= c_st_fixup;
        end
        c_st_fixup: begin
          r_result <= w_fix_res;
          r_state  <= c_st_done;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign md.busy   = (r_state == c_st_mul) || (r_state == c_st_div) || (r_state == c_st_fixup);
  assign md.valid  = (r_state == c_st_done);
  assign md.result = r_result;

endmodule

`default_nettype wire
